dmem_subword: RTL and testbench

//  Data-memory responder for the single-cycle MIPS core: accepts sw/sh/sb stores on the 2-bit memwrite bus.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/dmem_lane_steer.sv | 39 +++
 rtl/dmem_subword.sv | 106 ++++++++++
 tb/tb_dmem_subword.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the MIPS data-memory slice.
// Store-count statistics are enabled by defining DMEM_STATS_EN.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_SW   = 2'b01,
        MW_SH   = 2'b10,
        MW_SB   = 2'b11
    } memwrite_t;

    typedef enum logic [1:0] {
        LS_WORD = 2'b00,
        LS_HALF = 2'b01,
        LS_BYTE = 2'b10
    } loadsize_t;

    localparam int unsigned STORE_CNT_W = 16;

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational store steering: byte enables, replicated store data and
// alignment status for one store request.
module dmem_lane_steer
    import mips_mem_pkg::*;
(
    input  logic [1:0]  memwrite,
    input  logic [1:0]  a_lo,
    input  logic [31:0] wd,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_steered,
    output logic        aligned
);

    always_comb begin
        byte_en       = '0;
        wdata_steered = wd;
        aligned       = 1'b1;
        case (memwrite)
            MW_SW: begin
                aligned = (a_lo == 2'b00);
                byte_en = aligned ? 4'b1111 : 4'b0000;
            end
            MW_SH: begin
                // Replicate so either half-word lane pair sees the data.
                wdata_steered = {2{wd[15:0]}};
                aligned       = ~a_lo[0];
                if (aligned) byte_en = a_lo[1] ? 4'b1100 : 4'b0011;
            end
            MW_SB: begin
                wdata_steered = {4{wd[7:0]}};
                byte_en       = 4'b0001 << a_lo;
            end
            default: begin
                byte_en = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_subword.sv
// Data memory with sub-word stores/loads and sticky misaligned-store record.
// Optional store counter enabled by DMEM_STATS_EN.
module dmem_subword
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            a,
    input  logic [31:0]            wd,
    input  logic [1:0]             memwrite,
    input  logic [1:0]             loadsize,
    input  logic                   loadsigned,
    output logic [31:0]            rd,
    output logic                   misaligned,
    output logic [31:0]            err_addr,
    output logic [STORE_CNT_W-1:0] store_cnt
);

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] widx;
    logic [3:0]        byte_en;
    logic [31:0]       wdata;
    logic              aligned;
    logic              commit;
    logic              bad_store;
    logic              misaligned_q;
    logic [31:0]       err_addr_q;
    logic              unused_a_hi;

    assign widx        = a[ADDR_W+1:2];
    assign unused_a_hi = ^a[31:ADDR_W+2];

    dmem_lane_steer u_steer (
        .memwrite      (memwrite),
        .a_lo          (a[1:0]),
        .wd            (wd),
        .byte_en       (byte_en),
        .wdata_steered (wdata),
        .aligned       (aligned)
    );

    assign commit    = ~reset & (|byte_en);
    assign bad_store = ~reset & (memwrite != MW_NONE) & ~aligned;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (byte_en[k]) mem_q[widx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
            err_addr_q   <= '0;
        end else if (bad_store && !misaligned_q) begin
            misaligned_q <= 1'b1;
            err_addr_q   <= a;
        end
    end

    assign misaligned = misaligned_q;
    assign err_addr   = err_addr_q;

`ifdef DMEM_STATS_EN
    logic [STORE_CNT_W-1:0] store_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            store_cnt_q <= '0;
        end else if (commit && store_cnt_q != '1) begin
            store_cnt_q <= store_cnt_q + STORE_CNT_W'(1);
        end
    end

    assign store_cnt = store_cnt_q;
`else
    assign store_cnt = '0;
`endif

    logic [31:0] word;
    logic [15:0] half;
    logic [7:0]  byte_v;

    always_comb begin
        word   = mem_q[widx];
        half   = a[1] ? word[31:16] : word[15:0];
        byte_v = word[7:0];
        case (a[1:0])
            2'b01:   byte_v = word[15:8];
            2'b10:   byte_v = word[23:16];
            2'b11:   byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        case (loadsize)
            LS_HALF: rd = {{16{loadsigned & half[15]}}, half};
            LS_BYTE: rd = {{24{loadsigned & byte_v[7]}}, byte_v};
            default: rd = word;
        endcase
    end

endmodule

// File: tb/tb_dmem_subword.sv
// Self-checking bench for dmem_subword against a byte-addressed reference memory.
module tb_dmem_subword;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  memwrite;
    logic [1:0]  loadsize;
    logic        loadsigned;
    logic [31:0] rd;
    logic        misaligned;
    logic [31:0] err_addr;
    logic [15:0] store_cnt;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ref_mem [256];
    logic        ref_mis;
    logic [31:0] ref_err;
    int unsigned ref_cnt;

    always #5 clk = ~clk;

    dmem_subword #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .wd         (wd),
        .memwrite   (memwrite),
        .loadsize   (loadsize),
        .loadsigned (loadsigned),
        .rd         (rd),
        .misaligned (misaligned),
        .err_addr   (err_addr),
        .store_cnt  (store_cnt)
    );

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] ls, input logic sgn);
        int unsigned n, base;
        logic [31:0] v;
        n    = (ls == 2'd1) ? 2 : (ls == 2'd2) ? 1 : 4;
        base = ((addr % 256) / n) * n;
        v    = 0;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [1:0] mw, input logic rst);
        int unsigned n, base;
        logic ok;
        if (rst) begin
            ref_mis = 1'b0;
            ref_err = 0;
            ref_cnt = 0;
            return;
        end
        if (mw == 2'd0) return;
        n    = (mw == 2'd1) ? 4 : (mw == 2'd2) ? 2 : 1;
        ok   = (addr % n) == 0;
        base = addr % 256;
        if (ok) begin
            for (int unsigned i = 0; i < n; i++) ref_mem[base + i] = data[8*i +: 8];
            if (ref_cnt < 65535) ref_cnt = ref_cnt + 1;
        end else if (!ref_mis) begin
            ref_mis = 1'b1;
            ref_err = addr;
        end
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef DMEM_STATS_EN
        return 16'(ref_cnt);
`else
        return 16'h0;
`endif
    endfunction

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] mw, input logic rst);
        @(negedge clk);
        a = addr; wd = data; memwrite = mw; reset = rst;
        loadsize = 2'd0; loadsigned = 1'b0;
        @(posedge clk);
        model_store(addr, data, mw, rst);
        #1;
        memwrite = 2'd0;
        reset    = 1'b0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [1:0] ls, input logic sgn);
        @(negedge clk);
        a = addr; loadsize = ls; loadsigned = sgn; memwrite = 2'd0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; memwrite = 2'd0; a = 0; wd = 0; loadsize = 0; loadsigned = 0;
        ref_mis = 1'b0; ref_err = 0; ref_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
        checks++;
        if (err_addr !== 32'h0) begin failures++; $display("FAIL reset_err_addr: got %h expected 0", err_addr); end
        checks++;
        if (store_cnt !== 16'h0) begin failures++; $display("FAIL reset_store_cnt: got %h expected 0", store_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_ram_survives_reset();
        logic [31:0] exp;
        for (int unsigned w = 0; w < 64; w++) do_store(w * 4, $urandom, 2'd1, 1'b0);
        do_store(0, 0, 2'd0, 1'b1);
        for (int unsigned w = 0; w < 64; w += 21) begin
            set_load(w * 4, 2'd0, 1'b0);
            exp = model_load(w * 4, 2'd0, 1'b0);
            checks++;
            if (rd !== exp) begin failures++; $display("FAIL ram_kept_w%0d: got %h expected %h", w, rd, exp); end
        end
        checks++;
        if (store_cnt !== 16'h0) begin failures++; $display("FAIL cnt_after_reset: got %h expected 0", store_cnt); end
    endtask

    task automatic test_directed();
        logic [31:0] pre84;
        do_store(80, 32'hDEADBEEF, 2'd1, 1'b0);
        set_load(80, 2'd0, 1'b0);
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL t1_lw80: got %h expected deadbeef", rd); end
        checks++;
        if (store_cnt !== exp_cnt()) begin failures++; $display("FAIL t1_cnt: got %h expected %h", store_cnt, exp_cnt()); end

        do_store(80, 32'h0, 2'd1, 1'b0);
        do_store(80, 32'h000000FF, 2'd3, 1'b0);
        do_store(81, 32'h000000AA, 2'd3, 1'b0);
        set_load(80, 2'd0, 1'b0);
        checks++;
        if (rd !== 32'h0000AAFF) begin failures++; $display("FAIL t2_lw80: got %h expected 0000aaff", rd); end
        set_load(81, 2'd2, 1'b0);
        checks++;
        if (rd !== 32'h000000AA) begin failures++; $display("FAIL t2_lbu81: got %h expected 000000aa", rd); end
        set_load(81, 2'd2, 1'b1);
        checks++;
        if (rd !== 32'hFFFFFFAA) begin failures++; $display("FAIL t2_lb81: got %h expected ffffffaa", rd); end

        do_store(82, 32'h12348001, 2'd2, 1'b0);
        set_load(80, 2'd0, 1'b0);
        checks++;
        if (rd !== 32'h8001AAFF) begin failures++; $display("FAIL t3_lw80: got %h expected 8001aaff", rd); end
        set_load(82, 2'd1, 1'b1);
        checks++;
        if (rd !== 32'hFFFF8001) begin failures++; $display("FAIL t3_lh82: got %h expected ffff8001", rd); end
        set_load(83, 2'd1, 1'b0);
        checks++;
        if (rd !== 32'h00008001) begin failures++; $display("FAIL t3_lhu83: got %h expected 00008001", rd); end

        pre84 = model_load(84, 2'd0, 1'b0);
        do_store(86, 32'h76543210, 2'd1, 1'b0);
        set_load(84, 2'd0, 1'b0);
        checks++;
        if (rd !== pre84) begin failures++; $display("FAIL t4_ram_kept: got %h expected %h", rd, pre84); end
        checks++;
        if (misaligned !== 1'b1) begin failures++; $display("FAIL t4_misaligned: got %b expected 1", misaligned); end
        checks++;
        if (err_addr !== 32'd86) begin failures++; $display("FAIL t4_err_addr: got %h expected 00000056", err_addr); end
        do_store(85, 32'h0000BEEF, 2'd2, 1'b0);
        set_load(84, 2'd0, 1'b0);
        checks++;
        if (err_addr !== 32'd86) begin failures++; $display("FAIL t4_err_sticky: got %h expected 00000056", err_addr); end
        checks++;
        if (store_cnt !== exp_cnt()) begin failures++; $display("FAIL t4_cnt: got %h expected %h", store_cnt, exp_cnt()); end
        checks++;
        if (rd !== pre84) begin failures++; $display("FAIL t4_sh_dropped: got %h expected %h", rd, pre84); end

        do_store(80, 32'hCAFEF00D, 2'd1, 1'b1);
        set_load(80, 2'd0, 1'b0);
        checks++;
        if (rd !== 32'h8001AAFF) begin failures++; $display("FAIL t5_reset_blocks_store: got %h expected 8001aaff", rd); end
        checks++;
        if (misaligned !== 1'b0) begin failures++; $display("FAIL t5_misaligned: got %b expected 0", misaligned); end
        checks++;
        if (store_cnt !== 16'h0) begin failures++; $display("FAIL t5_cnt: got %h expected 0", store_cnt); end

        do_store(256, 32'h5A5A5A5A, 2'd1, 1'b0);
        set_load(0, 2'd0, 1'b0);
        checks++;
        if (rd !== 32'h5A5A5A5A) begin failures++; $display("FAIL t6_wrap: got %h expected 5a5a5a5a", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        logic [31:0] d;
        @(negedge clk);
        for (int unsigned k = 0; k < 4; k++) begin
            d = $urandom;
            a = 32'd120 + k; wd = d; memwrite = 2'd3; loadsize = 2'd0; loadsigned = 1'b0;
            #1;
            exp = model_load(120, 2'd0, 1'b0);
            checks++;
            if (rd !== exp) begin failures++; $display("FAIL b2b_pre_%0d: got %h expected %h", k, rd, exp); end
            @(posedge clk);
            model_store(32'd120 + k, d, 2'd3, 1'b0);
            #1;
            exp = model_load(120, 2'd0, 1'b0);
            checks++;
            if (rd !== exp) begin failures++; $display("FAIL b2b_post_%0d: got %h expected %h", k, rd, exp); end
        end
        memwrite = 2'd0;
        checks++;
        if (store_cnt !== exp_cnt()) begin failures++; $display("FAIL b2b_cnt: got %h expected %h", store_cnt, exp_cnt()); end
    endtask

    task automatic test_random();
        logic [31:0] addr, exp;
        logic [1:0]  ls;
        logic        sgn;
        for (int i = 0; i < 400; i++) begin
            addr = $urandom;
            if ($urandom_range(0, 9) < 5) begin
                do_store(addr, $urandom, 2'($urandom_range(1, 3)), $urandom_range(0, 39) == 0);
                @(negedge clk);
                checks++;
                if (misaligned !== ref_mis) begin failures++; $display("FAIL rnd_mis_%0d: got %b expected %b", i, misaligned, ref_mis); end
                checks++;
                if (err_addr !== ref_err) begin failures++; $display("FAIL rnd_err_%0d: got %h expected %h", i, err_addr, ref_err); end
                checks++;
                if (store_cnt !== exp_cnt()) begin failures++; $display("FAIL rnd_cnt_%0d: got %h expected %h", i, store_cnt, exp_cnt()); end
            end else begin
                ls  = 2'($urandom_range(0, 3));
                sgn = 1'($urandom_range(0, 1));
                set_load(addr, ls, sgn);
                exp = model_load(addr, ls, sgn);
                checks++;
                if (rd !== exp) begin failures++; $display("FAIL rnd_load_%0d: a=%h size=%0d sgn=%b got %h expected %h", i, addr, ls, sgn, rd, exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_survives_reset();
        test_directed();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
